// File: rtl/mem_ctrl_pkg.sv
// Shared types for the IF/D memory arbiter: access sizes,
// FSM state and owner encodings.
package mem_ctrl_pkg;

  localparam logic [1:0] SZ_1W  = 2'b00;
  localparam logic [1:0] SZ_4W  = 2'b01;
  localparam logic [1:0] SZ_8W  = 2'b10;
  localparam logic [1:0] SZ_16W = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    ISSUE = 2'b01,
    RDATA = 2'b10
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  function automatic logic [4:0] beat_count(
    input logic [1:0] sz
  );
    logic [4:0] n;
    n = 5'd1;
    case (sz)
      SZ_1W:   n = 5'd1;
      SZ_4W:   n = 5'd4;
      SZ_8W:   n = 5'd8;
      SZ_16W:  n = 5'd16;
      default: n = 5'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = IF, bit 1 = D.
// A tie goes to whichever side was not served last.
module mem_rr_arb2
  import mem_ctrl_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  input  logic       advance,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (advance) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_owner == OWN_IF)
                       ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory between instruction fetch bursts and
// single-word data accesses; all outputs registered.
module mem_arbiter
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_RD_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  input  logic [1:0]            if_size,
  output logic                  if_gnt,
  output logic [DATA_WIDTH-1:0] if_rdata,
  output logic                  if_rvalid,
  output logic                  if_last,
  input  logic                  d_req,
  input  logic                  d_rw,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  d_rvalid,
  output logic                  mem_enable,
  output logic                  mem_rw,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [1:0]            mem_access_size,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic                  mem_busy,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int LW =
    $clog2(MEM_RD_LATENCY + 1);
  localparam logic [LW-1:0] LAT0 =
    LW'(MEM_RD_LATENCY - 1);
  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ~ADDR_WIDTH'(3);

  state_e                state_q, state_d;
  owner_e                owner_q, owner_d;
  owner_e                last_q, last_d;
  logic [4:0]            cnt_q, cnt_d;
  logic [LW-1:0]         lat_q, lat_d;
  logic                  if_gnt_q, if_gnt_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic                  if_rvalid_q, if_rvalid_d;
  logic                  if_last_q, if_last_d;
  logic                  d_gnt_q, d_gnt_d;
  logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;
  logic                  d_rvalid_q, d_rvalid_d;
  logic                  men_q, men_d;
  logic                  mrw_q, mrw_d;
  logic [ADDR_WIDTH-1:0] maddr_q, maddr_d;
  logic [1:0]            msz_q, msz_d;
  logic [DATA_WIDTH-1:0] mwd_q, mwd_d;

  logic [1:0] req_v;
  logic [1:0] gnt;

  // A requester sees its gnt one cycle late, so its
  // still-high req must not win a second time.
  assign req_v = {d_req & ~d_gnt_q,
                  if_req & ~if_gnt_q};

  mem_rr_arb2 u_arb (
    .req        (req_v),
    .last_owner (last_q),
    .advance    (state_q == IDLE),
    .gnt        (gnt)
  );

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    lat_d       = lat_q;
    if_gnt_d    = 1'b0;
    d_gnt_d     = 1'b0;
    if_rvalid_d = 1'b0;
    if_last_d   = 1'b0;
    d_rvalid_d  = 1'b0;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    men_d       = men_q;
    mrw_d       = mrw_q;
    maddr_d     = maddr_q;
    msz_d       = msz_q;
    mwd_d       = mwd_q;
    unique case (state_q)
      IDLE: begin
        if (gnt[1]) begin
          owner_d = OWN_D;
          state_d = ISSUE;
          men_d   = 1'b1;
          mrw_d   = d_rw;
          maddr_d = d_addr & AMASK;
          msz_d   = SZ_1W;
          mwd_d   = d_wdata;
        end else if (gnt[0]) begin
          owner_d = OWN_IF;
          state_d = ISSUE;
          men_d   = 1'b1;
          mrw_d   = 1'b0;
          maddr_d = if_addr & AMASK;
          msz_d   = if_size;
          mwd_d   = '0;
        end
      end
      ISSUE: begin
        if (!mem_busy) begin
          men_d  = 1'b0;
          last_d = owner_q;
          if (owner_q == OWN_D) d_gnt_d = 1'b1;
          else if_gnt_d = 1'b1;
          if (mrw_q) begin
            state_d = IDLE;
          end else begin
            state_d = RDATA;
            cnt_d   = beat_count(msz_q);
            lat_d   = LAT0;
          end
        end
      end
      RDATA: begin
        if (lat_q != '0) begin
          lat_d = lat_q - LW'(1);
        end else begin
          if (owner_q == OWN_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
            if_last_d   = (cnt_q == 5'd1);
          end else begin
            d_rvalid_d = 1'b1;
            d_rdata_d  = mem_rdata;
          end
          cnt_d = cnt_q - 5'd1;
          if (cnt_q == 5'd1) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_IF;
      cnt_q       <= '0;
      lat_q       <= '0;
      if_gnt_q    <= 1'b0;
      if_rdata_q  <= '0;
      if_rvalid_q <= 1'b0;
      if_last_q   <= 1'b0;
      d_gnt_q     <= 1'b0;
      d_rdata_q   <= '0;
      d_rvalid_q  <= 1'b0;
      men_q       <= 1'b0;
      mrw_q       <= 1'b0;
      maddr_q     <= '0;
      msz_q       <= '0;
      mwd_q       <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      lat_q       <= lat_d;
      if_gnt_q    <= if_gnt_d;
      if_rdata_q  <= if_rdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_last_q   <= if_last_d;
      d_gnt_q     <= d_gnt_d;
      d_rdata_q   <= d_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      men_q       <= men_d;
      mrw_q       <= mrw_d;
      maddr_q     <= maddr_d;
      msz_q       <= msz_d;
      mwd_q       <= mwd_d;
    end
  end

  assign if_gnt          = if_gnt_q;
  assign if_rdata        = if_rdata_q;
  assign if_rvalid       = if_rvalid_q;
  assign if_last         = if_last_q;
  assign d_gnt           = d_gnt_q;
  assign d_rdata         = d_rdata_q;
  assign d_rvalid        = d_rvalid_q;
  assign mem_enable      = men_q;
  assign mem_rw          = mrw_q;
  assign mem_addr        = maddr_q;
  assign mem_access_size = msz_q;
  assign mem_data_in     = mwd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory
// and per-port read-beat scoreboards.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        if_req;
  logic [31:0] if_addr;
  logic [1:0]  if_size;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  logic        if_last;
  logic        d_req;
  logic        d_rw;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        mem_enable;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [1:0]  mem_access_size;
  logic [31:0] mem_data_in;
  logic        mem_busy;
  logic [31:0] mem_rdata = '0;

  int errors = 0;
  int checks = 0;

  logic [32:0] if_q[$];
  logic [31:0] d_q[$];

  mem_arbiter dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .if_req          (if_req),
    .if_addr         (if_addr),
    .if_size         (if_size),
    .if_gnt          (if_gnt),
    .if_rdata        (if_rdata),
    .if_rvalid       (if_rvalid),
    .if_last         (if_last),
    .d_req           (d_req),
    .d_rw            (d_rw),
    .d_addr          (d_addr),
    .d_wdata         (d_wdata),
    .d_gnt           (d_gnt),
    .d_rdata         (d_rdata),
    .d_rvalid        (d_rvalid),
    .mem_enable      (mem_enable),
    .mem_rw          (mem_rw),
    .mem_addr        (mem_addr),
    .mem_access_size (mem_access_size),
    .mem_data_in     (mem_data_in),
    .mem_busy        (mem_busy),
    .mem_rdata       (mem_rdata)
  );

  always #5 clock = ~clock;

  function automatic int nbeats(input logic [1:0] s);
    case (s)
      2'b00:   return 1;
      2'b01:   return 4;
      2'b10:   return 8;
      default: return 16;
    endcase
  endfunction

  // behavioural memory: read beats start the cycle after accept
  logic [31:0] mem [0:255];
  logic        mem_init = 1'b0;
  logic        m_acc, m_rw;
  logic [31:0] m_a, m_wd, rd_addr;
  logic [1:0]  m_sz;
  int          rd_left = 0;

  always @(posedge clock) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++)
        mem[i] = 32'hC0DE_0000 + i;
      mem[16] = 32'h11;
      mem[17] = 32'h22;
      mem[18] = 32'h33;
      mem[19] = 32'h44;
      mem_init = 1'b1;
    end
    m_acc = mem_enable && !mem_busy;
    m_rw  = mem_rw;
    m_a   = mem_addr;
    m_sz  = mem_access_size;
    m_wd  = mem_data_in;
    #1;
    if (rd_left > 0) begin
      rd_left--;
      rd_addr += 4;
    end
    if (m_acc) begin
      if (m_rw) begin
        mem[m_a[9:2]] = m_wd;
      end else begin
        rd_left = nbeats(m_sz);
        rd_addr = m_a;
      end
    end
    mem_rdata = (rd_left > 0) ? mem[rd_addr[9:2]] : '0;
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h want %0h",
             tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset_n === 1'b1) begin
      if (if_rvalid) begin
        if (if_q.size() == 0)
          chk("if_unexpected", 128'(if_rvalid), 0);
        else
          chk("if_beat", {if_last, if_rdata},
              if_q.pop_front());
      end
      if (d_rvalid) begin
        if (d_q.size() == 0)
          chk("d_unexpected", 128'(d_rvalid), 0);
        else
          chk("d_beat", d_rdata, d_q.pop_front());
      end
    end
  end

  task automatic raise_if(input logic [31:0] a,
                          input logic [1:0] s);
    int n;
    logic [31:0] wa;
    if_req  = 1'b1;
    if_addr = a;
    if_size = s;
    n  = nbeats(s);
    wa = a;
    for (int i = 0; i < n; i++) begin
      if_q.push_back({(i == n - 1), mem[wa[9:2]]});
      wa += 4;
    end
  endtask

  task automatic raise_d(input logic rw,
                         input logic [31:0] a,
                         input logic [31:0] wd);
    d_req   = 1'b1;
    d_rw    = rw;
    d_addr  = a;
    d_wdata = wd;
    if (!rw) d_q.push_back(mem[a[9:2]]);
  endtask

  task automatic wait_gnt(output int who);
    who = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (d_gnt) begin
        who = 1;
        d_req = 1'b0;
        return;
      end
      if (if_gnt) begin
        who = 0;
        if_req = 1'b0;
        return;
      end
    end
    checks++;
    errors++;
    $error("FAIL gnt_timeout: got none want gnt");
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (if_q.size() == 0 && d_q.size() == 0) begin
        @(negedge clock);
        return;
      end
    end
    checks++;
    errors++;
    $error("FAIL drain_timeout: got %0d want 0",
           if_q.size() + d_q.size());
  endtask

  function automatic logic [127:0] all_out();
    return {if_gnt, if_rvalid, if_last, d_gnt,
            d_rvalid, mem_enable, mem_rw,
            mem_access_size, if_rdata, d_rdata,
            mem_addr ^ mem_data_in};
  endfunction

  initial begin
    int w, w1, w2, exp_last, exp_w, beats;
    reset_n  = 1'b0;
    if_req   = 1'b0;
    if_addr  = '0;
    if_size  = '0;
    d_req    = 1'b0;
    d_rw     = 1'b0;
    d_addr   = '0;
    d_wdata  = '0;
    mem_busy = 1'b0;
    repeat (2) @(negedge clock);
    chk("reset_outs", all_out(), 0);
    chk("reset_addr", mem_addr, 0);
    reset_n = 1'b1;

    // single data write
    @(negedge clock);
    raise_d(1'b1, 32'h100, 32'hDEADBEEF);
    @(negedge clock);
    chk("wr_cmd", {mem_enable, mem_rw,
        mem_access_size, mem_addr, d_gnt},
        {1'b1, 1'b1, 2'b00, 32'h100, 1'b0});
    chk("wr_data", mem_data_in, 32'hDEADBEEF);
    @(negedge clock);
    chk("wr_gnt", {d_gnt, mem_enable}, 2'b10);
    d_req = 1'b0;
    @(negedge clock);
    chk("wr_after", {d_gnt, d_rvalid, mem_enable}, 0);

    // 4-word fetch burst at minimum latency
    raise_if(32'h40, 2'b01);
    @(negedge clock);
    chk("if_cmd", {mem_enable, mem_rw,
        mem_access_size, mem_addr},
        {1'b1, 1'b0, 2'b01, 32'h40});
    @(negedge clock);
    chk("if_gnt", {if_gnt, mem_enable}, 2'b10);
    if_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("if_burst_v", {if_rvalid, if_last},
          {1'b1, (i == 3)});
    end
    @(negedge clock);
    chk("if_burst_end", {if_rvalid, mem_enable}, 0);
    drain();

    // simultaneous requests straight after reset
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    exp_last = 0;
    for (int r = 0; r < 3; r++) begin
      raise_if(32'h80 + 32'(r * 4), 2'b00);
      raise_d(1'b0, 32'h108 + 32'(r * 4), '0);
      wait_gnt(w1);
      exp_w = (exp_last == 0) ? 1 : 0;
      chk("tie_first", 128'(w1), 128'(exp_w));
      wait_gnt(w2);
      chk("tie_second", 128'(w2), 128'(1 - exp_w));
      exp_last = 1 - exp_w;
      drain();
    end

    // memory busy holds the command
    mem_busy = 1'b1;
    raise_if(32'h20, 2'b10);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("busy_hold", {mem_enable, mem_addr,
          mem_access_size, if_gnt},
          {1'b1, 32'h20, 2'b10, 1'b0});
    end
    mem_busy = 1'b0;
    @(negedge clock);
    chk("busy_gnt", {if_gnt, mem_enable}, 2'b10);
    if_req = 1'b0;
    drain();

    // reset in the middle of a 16-word burst
    raise_if(32'h0, 2'b11);
    wait_gnt(w);
    beats = 0;
    for (int i = 0; i < 40 && beats < 5; i++) begin
      @(negedge clock);
      if (if_rvalid) beats++;
    end
    chk("mid_beats", 128'(beats), 5);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mid_reset", all_out(), 0);
    if_q.delete();
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 14; i++) begin
      @(negedge clock);
      chk("post_rst_quiet", {if_rvalid, if_last}, 0);
    end

    // unaligned data read after reset
    raise_d(1'b0, 32'h103, '0);
    @(negedge clock);
    chk("ua_cmd", {mem_enable, mem_rw,
        mem_access_size, mem_addr},
        {1'b1, 1'b0, 2'b00, 32'h100});
    @(negedge clock);
    chk("ua_gnt", {d_gnt, if_gnt}, 2'b10);
    d_req = 1'b0;
    @(negedge clock);
    chk("ua_rd", {d_rvalid, if_rvalid, d_rdata},
        {1'b1, 1'b0, 32'hDEADBEEF});
    @(negedge clock);
    chk("ua_done", {d_rvalid, if_rvalid}, 0);

    chk("queues_empty",
        128'(if_q.size() + d_q.size()), 0);
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-port controller that shares the single byte-addressable memory between instruction fetch (IF, read-only, bursts) and data (D, single-word load/store).
- Arbitrates, drives the memory command (enable/rw/address/access_size/data_in), honours memory busy, and routes returned read beats to the owning requester.
- Sits between the pipeline front/back ends and the memory block.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 32, word width
MEM_RD_LATENCY, 1, cycles from memory command accept to first read beat on mem_rdata

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held with if_addr/if_size until if_gnt
if_addr  in  ADDR_WIDTH  fetch base byte address
if_size  in  2  burst size: 00=1, 01=4, 10=8, 11=16 words
if_gnt  out  1  one-cycle pulse: fetch command accepted by memory
if_rdata  out  DATA_WIDTH  fetch read word
if_rvalid  out  1  if_rdata valid this cycle
if_last  out  1  final beat of the fetch burst (with if_rvalid)
d_req  in  1  data request; held until d_gnt
d_rw  in  1  1=write, 0=read
d_addr  in  ADDR_WIDTH  data byte address
d_wdata  in  DATA_WIDTH  store data
d_gnt  out  1  one-cycle pulse: data command accepted
d_rdata  out  DATA_WIDTH  load word
d_rvalid  out  1  d_rdata valid
mem_enable  out  1  memory command valid
mem_rw  out  1  1=write, 0=read
mem_addr  out  ADDR_WIDTH  memory address, bits [1:0] forced 0
mem_access_size  out  2  memory access_size encoding
mem_data_in  out  DATA_WIDTH  write data to memory
mem_busy  in  1  memory busy; a command is accepted when mem_enable=1 and mem_busy=0
mem_rdata  in  DATA_WIDTH  memory read data

Behaviour:
- Reset (async, reset_n=0): all outputs 0, state IDLE, beat counter 0, last_owner=IF. Any burst in flight is abandoned; beats arriving after reset deasserts are ignored (not forwarded).
- All outputs are registered. States: IDLE, ISSUE, RDATA.
- IDLE: with no request, stay. With one request, grant it. With both, round-robin: the owner that is not last_owner wins. After reset D wins the first tie. Next cycle ISSUE, with mem_enable=1 and the command fields loaded.
- D command: access_size=00, rw=d_rw, data_in=d_wdata. IF command: access_size=if_size, rw=0.
- ISSUE: hold mem_enable and all command fields stable while mem_busy=1. On the accept edge (mem_busy=0): pulse the owner's gnt for 1 cycle, drop mem_enable, update last_owner.
  - Write: return to IDLE.
  - Read: go to RDATA, beat count loaded with 1/4/8/16.
- RDATA: the first beat is sampled MEM_RD_LATENCY cycles after accept, then one beat per consecutive cycle.
  - Each beat is registered to the owner's rdata with rvalid=1 for 1 cycle; the non-owner's rvalid stays 0.
  - if_last=1 on the final IF beat. D reads are always 1 beat.
  - After the final beat go to IDLE. New arbitration occurs in IDLE, so minimum gap between commands is 1 idle cycle.
- A request raised during ISSUE/RDATA waits; no preemption of a burst.
- Minimum latency: request in IDLE at cycle t gives mem_enable at t+1. With mem_busy=0, gnt at t+2 and first beat at t+1+MEM_RD_LATENCY+1.
- Unaligned addresses: low 2 bits dropped, no error. Burst address increment and wrap past top of memory belong to the memory block; the controller issues only the base.
- Requester dropping req before gnt: unsupported. The controller uses values latched in IDLE.

Decomposition:
- Package mem_ctrl_pkg: access_size encodings (SZ_1W..SZ_16W), size-to-beat-count function, state encoding (IDLE/ISSUE/RDATA), owner encoding (OWN_IF/OWN_D).
- Sub-module mem_rr_arb2: 2-way round-robin arbiter (req[1:0], last_owner, advance → grant one-hot).

Test Plan:
- Reset then single d_req write, addr 0x100, wdata 0xDEADBEEF, mem_busy=0 → mem_enable at t+1 with rw=1, size=00, addr 0x100; d_gnt pulse at t+2; no rvalid.
- IF burst if_size=01 at 0x40, MEM_RD_LATENCY=1, memory returns 0x11,0x22,0x33,0x44 → four consecutive if_rvalid with those words, if_last only on 0x44, then IDLE.
- if_req and d_req both in the first cycle after reset → D granted first, IF next. Repeat simultaneous requests → grants alternate IF, D, IF.
- mem_busy held 3 cycles during ISSUE → mem_enable/mem_addr/mem_access_size stable for all 4 cycles; gnt only on the cycle busy=0.
- reset_n pulsed low mid 16-word burst after beat 5 → all outputs 0 immediately; remaining beats produce no if_rvalid; next d_req served normally.
- d_addr 0x103 read → mem_addr 0x100, one d_rvalid, if_rvalid stays 0.
